mem_init_seq: RTL and testbench

MEM_INIT_SEQ -- requirements
Module: mem_init_seq

---
 rtl/mem_init_seq_if.sv | 42 ++++
 rtl/mem_init_seq.sv | 127 ++++++++++++
 tb/tb_mem_init_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_init_seq_if.sv
// ----------------------------------------------------------------------------
// mem_init_seq_if
// Purpose : bundles the control handshake and memory-write bus of the
//           memory initialisation sequencer into one connection.
// Signals :
//   en        start request (requester -> sequencer)
//   mode      fill pattern select, 2 bits (requester -> sequencer)
//   fill_val  seed / constant operand, DATA_W bits (requester -> sequencer)
//   abort     stop the run in progress (requester -> sequencer)
//   rdy       sequencer idle and able to accept en
//   addr      memory write address, ADDR_W bits
//   wrdata    memory write data, DATA_W bits
//   wren      memory write enable, one word per cycle
//   done      one-cycle pulse after a run completes normally
// Modports: master = requester / memory side, slave = the sequencer itself.
// ----------------------------------------------------------------------------
interface mem_init_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);

  logic              en;
  logic [1:0]        mode;
  logic [DATA_W-1:0] fill_val;
  logic              abort;
  logic              rdy;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wrdata;
  logic              wren;
  logic              done;

  modport master (
    output en, mode, fill_val, abort,
    input  rdy, addr, wrdata, wren, done
  );

  modport slave (
    input  en, mode, fill_val, abort,
    output rdy, addr, wrdata, wren, done
  );

endinterface

// File: rtl/mem_init_seq.sv
// ----------------------------------------------------------------------------
// mem_init_seq
// Purpose : walks a memory from address 0 to DEPTH-1, writing one word per
//           cycle, with the data word generated from a selectable pattern:
//             mode 0  identity        data = i
//             mode 1  constant fill   data = fill_val
//             mode 2  descending      data = DEPTH-1-i
//             mode 3  offset ramp     data = fill_val + i (wraps)
//           All arithmetic wraps modulo 2**DATA_W.
// Ports   :
//   clk   single clock, all state changes on its rising edge
//   rst   synchronous active-high reset
//   bus   mem_init_seq_if.slave: en/mode/fill_val/abort in,
//         rdy/addr/wrdata/wren/done out (all outputs registered)
// Parameters: DATA_W data width, ADDR_W address width,
//             DEPTH words per run (1 .. 2**ADDR_W).
// ----------------------------------------------------------------------------
module mem_init_seq #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  mem_init_seq_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              done_q, done_d;

  // Data word for write index idx under pattern m. The address doubles as
  // the write index since every run starts at address 0. Widths are cast to
  // DATA_W so every pattern wraps rather than saturates.
  function automatic logic [DATA_W-1:0] patternWord(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] seed,
    input logic [ADDR_W-1:0] idx
  );
    logic [DATA_W-1:0] word;
    case (m)
      2'd0:    word = DATA_W'(idx);
      2'd1:    word = seed;
      2'd2:    word = DATA_W'(LastAddr - idx);
      default: word = seed + DATA_W'(idx);
    endcase
    return word;
  endfunction

  // Next-state and next-output logic. In IDLE a start request loads the
  // pattern registers and pre-computes the word for address 0, so the first
  // write appears in the cycle right after acceptance. Abort beats en in
  // IDLE, and in FILL it beats normal completion, so an aborted run never
  // raises done. Address and data simply hold whenever nothing is written.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    mode_d   = mode_q;
    fill_d   = fill_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && !bus.abort) begin
          state_d  = FILL;
          addr_d   = '0;
          mode_d   = bus.mode;
          fill_d   = bus.fill_val;
          wrdata_d = patternWord(bus.mode, bus.fill_val, '0);
        end
      end
      FILL: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (addr_q == LastAddr) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          addr_d   = addr_q + ADDR_W'(1);
          wrdata_d = patternWord(mode_q, fill_q, addr_q + ADDR_W'(1));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset clears everything, including the latched pattern
  // operands, and takes priority over any request or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wrdata_q <= '0;
      mode_q   <= '0;
      fill_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      done_q   <= done_d;
    end
  end

  // Outputs come straight from registers; rdy and wren are decodes of the
  // registered state.
  assign bus.rdy    = (state_q == IDLE);
  assign bus.wren   = (state_q == FILL);
  assign bus.addr   = addr_q;
  assign bus.wrdata = wrdata_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_mem_init_seq.sv
// ----------------------------------------------------------------------------
// tb_mem_init_seq
// Purpose : self-checking bench for mem_init_seq. Two instances are built:
//           the default 8/8/256 configuration and a 4-bit-address, 16-deep
//           one. A select bit chooses which instance receives en and which
//           one is observed. The reference model keeps the list of writes a
//           run still owes as a queue built from the pattern formulas.
// ----------------------------------------------------------------------------
module tb_mem_init_seq;

  logic       clk = 1'b0;
  logic       rstDrv = 1'b1;
  logic       enDrv = 1'b0;
  logic       abortDrv = 1'b0;
  logic [1:0] modeDrv = 2'd0;
  logic [7:0] valDrv = 8'd0;
  logic       sel = 1'b0;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: outstanding writes of the current run, pending
  // done pulse, and the address/data values last presented.
  int  qAddr[$];
  int  qData[$];
  bit  expDone = 1'b0;
  int  lastAddr = 0;
  int  lastData = 0;
  int  depthSel = 256;

  logic       obsRdy, obsWren, obsDone;
  logic [7:0] obsAddr, obsData;

  mem_init_seq_if #(.DATA_W(8), .ADDR_W(8)) bigIf ();
  mem_init_seq_if #(.DATA_W(8), .ADDR_W(4)) smallIf ();

  // 10 ns clock.
  always #5 clk = ~clk;

  // Only the selected instance sees en; the rest of the inputs are shared.
  assign bigIf.en         = enDrv & ~sel;
  assign bigIf.abort      = abortDrv;
  assign bigIf.mode       = modeDrv;
  assign bigIf.fill_val   = valDrv;
  assign smallIf.en       = enDrv & sel;
  assign smallIf.abort    = abortDrv;
  assign smallIf.mode     = modeDrv;
  assign smallIf.fill_val = valDrv;

  // Observation mux onto common 8-bit views.
  assign obsRdy  = sel ? smallIf.rdy  : bigIf.rdy;
  assign obsWren = sel ? smallIf.wren : bigIf.wren;
  assign obsDone = sel ? smallIf.done : bigIf.done;
  assign obsAddr = sel ? {4'b0000, smallIf.addr} : bigIf.addr;
  assign obsData = sel ? smallIf.wrdata : bigIf.wrdata;

  mem_init_seq #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dutBig (
    .clk (clk),
    .rst (rstDrv),
    .bus (bigIf)
  );

  mem_init_seq #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dutSmall (
    .clk (clk),
    .rst (rstDrv),
    .bus (smallIf)
  );

  // Pattern formulas straight from the pattern definitions.
  function automatic int refWord(input int m, input int v, input int i);
    case (m)
      0:       return i % 256;
      1:       return v;
      2:       return (depthSel - 1 - i) % 256;
      default: return (v + i) % 256;
    endcase
  endfunction

  // Advances the reference model across one rising edge using the inputs
  // currently being driven.
  task automatic modelAdvance();
    if (rstDrv) begin
      qAddr.delete();
      qData.delete();
      expDone  = 1'b0;
      lastAddr = 0;
      lastData = 0;
    end else if (qAddr.size() > 0) begin
      expDone  = 1'b0;
      lastAddr = qAddr[0];
      lastData = qData[0];
      if (abortDrv) begin
        qAddr.delete();
        qData.delete();
      end else begin
        void'(qAddr.pop_front());
        void'(qData.pop_front());
        if (qAddr.size() == 0) expDone = 1'b1;
      end
    end else begin
      expDone = 1'b0;
      if (enDrv && !abortDrv) begin
        for (int i = 0; i < depthSel; i++) begin
          qAddr.push_back(i);
          qData.push_back(refWord(int'(modeDrv), int'(valDrv), i));
        end
      end
    end
  endtask

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, steps the model, then samples all outputs
  // on the falling edge that follows the rising edge.
  task automatic applyStimulus(input logic en, input logic abort,
                               input logic rst, input logic [1:0] m,
                               input logic [7:0] v);
    bit expWren;
    enDrv    = en;
    abortDrv = abort;
    rstDrv   = rst;
    modeDrv  = m;
    valDrv   = v;
    modelAdvance();
    @(posedge clk);
    @(negedge clk);
    expWren = (qAddr.size() > 0);
    checkOutput("rdy",    32'(obsRdy),  32'(!expWren));
    checkOutput("wren",   32'(obsWren), 32'(expWren));
    checkOutput("done",   32'(obsDone), 32'(expDone));
    checkOutput("addr",   32'(obsAddr), expWren ? qAddr[0] : lastAddr);
    checkOutput("wrdata", 32'(obsData), expWren ? qData[0] : lastData);
  endtask

  // Starts a run and keeps stepping until the model says it has ended.
  // While busy, en/mode/fill_val are randomised (they must be ignored).
  // abortIdx / rstIdx name the address whose write cycle is followed by
  // abort / reset; -1 disables.
  task automatic runFill(input logic [1:0] m, input logic [7:0] v,
                         input int abortIdx, input int rstIdx);
    int guard;
    int front;
    guard = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, m, v);
    while (qAddr.size() > 0 && guard < 1000) begin
      front = qAddr[0];
      if (!sel && m == 2'd3 && v == 8'hF0 && front == 16)
        checkOutput("addr16", 32'(obsData), 32'h00);
      applyStimulus(1'($urandom_range(0, 1)), 1'(front == abortIdx),
                    1'(front == rstIdx), 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 255)));
      guard++;
    end
    if (guard >= 1000) checkOutput("timeout", 32'(guard), 32'd0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)),
                    8'($urandom_range(0, 255)));
  endtask

  initial begin
    int ab;
    // Reset, including en+abort held high to show reset wins.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 8'hFF);

    // Identity fill on the first edge out of reset, then offset ramp
    // back-to-back straight off the done cycle.
    runFill(2'd0, 8'h00, -1, -1);
    runFill(2'd3, 8'hF0, -1, -1);
    idleCycles(2);

    // Abort after address 5, then an immediate restart from address 0.
    runFill(2'd1, 8'h5A, 5, -1);
    runFill(2'd0, 8'h00, -1, -1);
    idleCycles(1);

    // en together with abort in idle must not start anything.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 8'h33);
    idleCycles(2);

    // Reset mid-run at address 100.
    runFill(2'd2, 8'h00, -1, 100);
    idleCycles(2);

    // Random runs, some aborted.
    for (int r = 0; r < 3; r++) begin
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : -1;
      runFill(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), ab, -1);
      idleCycles(int'($urandom_range(0, 2)));
    end

    // Switch to the 16-deep instance.
    sel = 1'b1;
    depthSel = 16;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 8'h00);

    // Descending fill, then constant AA back-to-back.
    runFill(2'd2, 8'h00, -1, -1);
    runFill(2'd1, 8'hAA, -1, -1);
    idleCycles(1);

    // Abort landing on the final write edge suppresses done.
    runFill(2'd3, 8'hFE, 15, -1);
    idleCycles(1);

    for (int r = 0; r < 8; r++) begin
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
      runFill(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), ab, -1);
      if ($urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 3)));
    end
    idleCycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
